// File: rtl/monster_fire_scheduler.sv
// monster_fire_scheduler
// Picks which alien monster fires next and which enemy projectile slot it
// launches into. Round-robin over monsters, lowest free slot, one grant per
// frame at most, with a per-level frame cooldown between shots.
module monster_fire_scheduler #(
  parameter int N_MON  = 8,
  parameter int N_SLOT = 4,
  parameter int CD_L1  = 60,
  parameter int CD_L2  = 30,
  localparam int ID_W  = (N_MON  > 1) ? $clog2(N_MON)  : 1,
  localparam int SL_W  = (N_SLOT > 1) ? $clog2(N_SLOT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        level_in,
  input  logic              frame_tick,
  input  logic [N_MON-1:0]  fire_req,
  input  logic [N_SLOT-1:0] slot_free,
  output logic              grant_valid,
  output logic [ID_W-1:0]   grant_id,
  output logic [SL_W-1:0]   grant_slot,
  output logic              cooling,
  output logic [7:0]        shots
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_CD = 2'd1,
    ST_ARB     = 2'd2,
    ST_GRANT   = 2'd3
  } state_t;

  // Pointer value that makes monster 0 the first candidate.
  localparam logic [ID_W-1:0] RR_INIT = ID_W'(N_MON - 1);

  state_t            state_r, state_s;
  logic [1:0]        lvl_r, lvl_s;
  logic [7:0]        cd_r, cd_s;
  logic [ID_W-1:0]   rr_r, rr_s;
  logic [7:0]        shots_r, shots_s;
  logic              grant_valid_r, grant_valid_s;
  logic [ID_W-1:0]   grant_id_r, grant_id_s;
  logic [SL_W-1:0]   grant_slot_r, grant_slot_s;
  logic              cooling_r;

  // Map the raw level code onto 0 (idle), 1 or 2; anything else is idle.
  function automatic logic [1:0] decode_level(input logic [2:0] lv);
    logic [1:0] res;
    case (lv)
      3'd1:    res = 2'd1;
      3'd2:    res = 2'd2;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  // Cooldown reload in frames for a decoded level.
  function automatic logic [7:0] reload_for(input logic [1:0] lv);
    logic [7:0] res;
    case (lv)
      2'd2:    res = 8'(CD_L2);
      default: res = 8'(CD_L1);
    endcase
    return res;
  endfunction

  // First requesting monster after ptr, wrapping through N_MON-1 back to 0.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_MON-1:0] req,
                                               input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    logic            found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= N_MON; k++) begin
      idx = ID_W'((int'(ptr) + k) % N_MON);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Lowest-index free projectile slot.
  function automatic logic [SL_W-1:0] slot_pick(input logic [N_SLOT-1:0] free);
    logic [SL_W-1:0] pick;
    logic [SL_W-1:0] idx;
    pick = '0;
    for (int j = N_SLOT - 1; j >= 0; j--) begin
      idx = SL_W'(j);
      if (free[idx]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  assign lvl_s = decode_level(level_in);

  // Next-state and datapath decisions; level changes override everything else.
  always_comb begin
    state_s       = state_r;
    cd_s          = cd_r;
    rr_s          = rr_r;
    shots_s       = shots_r;
    grant_valid_s = 1'b0;
    grant_id_s    = grant_id_r;
    grant_slot_s  = grant_slot_r;

    if (lvl_s == 2'd0) begin
      // Game idle: park with counters cleared, last grant indices kept.
      state_s = ST_IDLE;
      cd_s    = 8'd0;
      shots_s = 8'd0;
      rr_s    = RR_INIT;
    end else if (lvl_s != lvl_r) begin
      // New level: restart cooldown and statistics; a tick this cycle is dropped.
      state_s = ST_WAIT_CD;
      cd_s    = reload_for(lvl_s);
      shots_s = 8'd0;
      rr_s    = RR_INIT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Only reachable with a stable valid level after an upset; resume play.
          state_s = ST_WAIT_CD;
          cd_s    = reload_for(lvl_r);
        end
        ST_WAIT_CD: begin
          if (frame_tick) begin
            cd_s = (cd_r == 8'd0) ? 8'd0 : (cd_r - 8'd1);
            if (cd_s == 8'd0) begin
              state_s = ST_ARB;
            end else begin
              state_s = ST_WAIT_CD;
            end
          end else if (cd_r == 8'd0) begin
            state_s = ST_ARB;
          end else begin
            state_s = ST_WAIT_CD;
          end
        end
        ST_ARB: begin
          if (frame_tick && (|fire_req) && (|slot_free)) begin
            state_s       = ST_GRANT;
            grant_valid_s = 1'b1;
            grant_id_s    = rr_pick(fire_req, rr_r);
            grant_slot_s  = slot_pick(slot_free);
          end else begin
            state_s = ST_ARB;
          end
        end
        ST_GRANT: begin
          state_s = ST_WAIT_CD;
          cd_s    = reload_for(lvl_r);
          rr_s    = grant_id_r;
          shots_s = (shots_r == 8'hFF) ? shots_r : (shots_r + 8'd1);
        end
        default: begin
          state_s = ST_IDLE;
          cd_s    = 8'd0;
          shots_s = 8'd0;
          rr_s    = RR_INIT;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      lvl_r         <= 2'd0;
      cd_r          <= 8'd0;
      rr_r          <= RR_INIT;
      shots_r       <= 8'd0;
      grant_valid_r <= 1'b0;
      grant_id_r    <= '0;
      grant_slot_r  <= '0;
      cooling_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      lvl_r         <= lvl_s;
      cd_r          <= cd_s;
      rr_r          <= rr_s;
      shots_r       <= shots_s;
      grant_valid_r <= grant_valid_s;
      grant_id_r    <= grant_id_s;
      grant_slot_r  <= grant_slot_s;
      cooling_r     <= (cd_s != 8'd0);
    end
  end

  assign grant_valid = grant_valid_r;
  assign grant_id    = grant_id_r;
  assign grant_slot  = grant_slot_r;
  assign cooling     = cooling_r;
  assign shots       = shots_r;

endmodule

// File: tb/tb_monster_fire_scheduler.sv
// Directed testbench for monster_fire_scheduler.
module tb_monster_fire_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] level_in;
  logic       frame_tick;
  logic [7:0] fire_req;
  logic [3:0] slot_free;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic [1:0] grant_slot;
  logic       cooling;
  logic [7:0] shots;

  int n_checks = 0;
  int n_fail   = 0;

  monster_fire_scheduler #(
    .N_MON(8), .N_SLOT(4), .CD_L1(60), .CD_L2(30)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .level_in   (level_in),
    .frame_tick (frame_tick),
    .fire_req   (fire_req),
    .slot_free  (slot_free),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .grant_slot (grant_slot),
    .cooling    (cooling),
    .shots      (shots)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle frame_tick; returns 1 ns after the edge that samples it.
  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; level_in = 3'd0; frame_tick = 1'b0;
    fire_req = 8'h00; slot_free = 4'h0;
    step(2);
    n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gv got=%b exp=0", grant_valid); end
    n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL reset_id got=%0d exp=0", grant_id); end
    n_checks++; if (grant_slot !== 2'd0) begin n_fail++; $display("FAIL reset_slot got=%0d exp=0", grant_slot); end
    n_checks++; if (cooling !== 1'b0) begin n_fail++; $display("FAIL reset_cooling got=%b exp=0", cooling); end
    n_checks++; if (shots !== 8'd0) begin n_fail++; $display("FAIL reset_shots got=%0d exp=0", shots); end
    rst = 1'b0;
    step(1);
    fire_req = 8'hFF; slot_free = 4'hF;
    tick();
    n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_grant got=%b exp=0", grant_valid); end
    step(2);
  endtask

  // T1: level 1 with no requests; cooldown of 60 frames.
  task automatic test_cooldown_l1();
    int fall;
    logic seen;
    fall = 0; seen = 1'b0;
    fire_req = 8'h00; slot_free = 4'hF; level_in = 3'd1;
    step(1);
    n_checks++; if (cooling !== 1'b1) begin n_fail++; $display("FAIL l1_cooling_start got=%b exp=1", cooling); end
    for (int t = 1; t <= 70; t++) begin
      tick();
      if (grant_valid) seen = 1'b1;
      if (!cooling && fall == 0) fall = t;
      step(2);
    end
    n_checks++; if (fall !== 60) begin n_fail++; $display("FAIL l1_cool_fall got=%0d exp=60", fall); end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL l1_no_req_grant got=%b exp=0", seen); end
  endtask

  // T2: round-robin and slot pick, then the next grant after the cooldown.
  task automatic test_round_robin();
    int got_at, t;
    logic [2:0] id_seen;
    logic [1:0] slot_seen;
    fire_req = 8'h24; slot_free = 4'hC;
    tick();
    n_checks++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL rr_first_gv got=%b exp=1", grant_valid); end
    n_checks++; if (grant_id !== 3'd2) begin n_fail++; $display("FAIL rr_first_id got=%0d exp=2", grant_id); end
    n_checks++; if (grant_slot !== 2'd2) begin n_fail++; $display("FAIL rr_first_slot got=%0d exp=2", grant_slot); end
    step(1);
    n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL rr_pulse_width got=%b exp=0", grant_valid); end
    n_checks++; if (shots !== 8'd1) begin n_fail++; $display("FAIL rr_shots1 got=%0d exp=1", shots); end
    step(1);
    got_at = 0; t = 0; id_seen = 3'd0; slot_seen = 2'd0;
    while (got_at == 0 && t < 70) begin
      tick();
      t++;
      if (grant_valid) begin got_at = t; id_seen = grant_id; slot_seen = grant_slot; end
      step(2);
    end
    n_checks++; if (got_at < 60 || got_at > 61) begin n_fail++; $display("FAIL rr_second_spacing got=%0d exp=60..61", got_at); end
    n_checks++; if (id_seen !== 3'd5) begin n_fail++; $display("FAIL rr_second_id got=%0d exp=5", id_seen); end
    n_checks++; if (slot_seen !== 2'd2) begin n_fail++; $display("FAIL rr_second_slot got=%0d exp=2", slot_seen); end
    n_checks++; if (shots !== 8'd2) begin n_fail++; $display("FAIL rr_shots2 got=%0d exp=2", shots); end
  endtask

  // T5: level 1 -> 2 on the same cycle as a tick during the cooldown.
  task automatic test_level_change_tick();
    int n;
    fire_req = 8'h00;
    for (int i = 0; i < 3; i++) begin tick(); step(2); end
    level_in = 3'd2; frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    n_checks++; if (shots !== 8'd0) begin n_fail++; $display("FAIL lc_shots got=%0d exp=0", shots); end
    n_checks++; if (cooling !== 1'b1) begin n_fail++; $display("FAIL lc_cooling got=%b exp=1", cooling); end
    step(2);
    n = 0;
    while (cooling && n < 40) begin tick(); n++; step(2); end
    n_checks++; if (n !== 30) begin n_fail++; $display("FAIL lc_reload_ticks got=%0d exp=30", n); end
  endtask

  // T3: all monsters requesting at level 2; ids rotate 0..7 then 0.
  task automatic test_level2_rr();
    logic got;
    int n;
    logic [2:0] idv, exp_id;
    logic [1:0] slv;
    fire_req = 8'hFF; slot_free = 4'h1;
    for (int g = 0; g < 9; g++) begin
      got = 1'b0; n = 0; idv = 3'd0; slv = 2'd3;
      exp_id = 3'(g % 8);
      while (!got && n < 40) begin
        tick();
        n++;
        if (grant_valid) begin got = 1'b1; idv = grant_id; slv = grant_slot; end
        step(2);
      end
      n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL l2_grant%0d_timeout got=%b exp=1", g, got); end
      n_checks++; if (idv !== exp_id) begin n_fail++; $display("FAIL l2_grant%0d_id got=%0d exp=%0d", g, idv, exp_id); end
      n_checks++; if (slv !== 2'd0) begin n_fail++; $display("FAIL l2_grant%0d_slot got=%0d exp=0", g, slv); end
    end
    n_checks++; if (shots !== 8'd9) begin n_fail++; $display("FAIL l2_shots got=%0d exp=9", shots); end
  endtask

  // T4: arbitration stalls while no slot is free.
  task automatic test_no_slot();
    int n, bad;
    slot_free = 4'h0; fire_req = 8'hFF;
    n = 0;
    while (cooling && n < 40) begin tick(); n++; step(2); end
    n_checks++; if (cooling !== 1'b0) begin n_fail++; $display("FAIL ns_cool_timeout got=%b exp=0", cooling); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (grant_valid) bad++;
      step(2);
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ns_stall_grants got=%0d exp=0", bad); end
    slot_free = 4'h8;
    tick();
    n_checks++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL ns_gv got=%b exp=1", grant_valid); end
    n_checks++; if (grant_slot !== 2'd3) begin n_fail++; $display("FAIL ns_slot got=%0d exp=3", grant_slot); end
    n_checks++; if (grant_id !== 3'd1) begin n_fail++; $display("FAIL ns_id got=%0d exp=1", grant_id); end
    step(3);
  endtask

  // Invalid level forces idle; grant indices are retained.
  task automatic test_level_idle();
    int bad;
    level_in = 3'd5;
    step(1);
    n_checks++; if (cooling !== 1'b0) begin n_fail++; $display("FAIL li_cooling got=%b exp=0", cooling); end
    n_checks++; if (shots !== 8'd0) begin n_fail++; $display("FAIL li_shots got=%0d exp=0", shots); end
    n_checks++; if (grant_id !== 3'd1) begin n_fail++; $display("FAIL li_id_hold got=%0d exp=1", grant_id); end
    n_checks++; if (grant_slot !== 2'd3) begin n_fail++; $display("FAIL li_slot_hold got=%0d exp=3", grant_slot); end
    fire_req = 8'hFF; slot_free = 4'hF;
    bad = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (grant_valid) bad++; step(2); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL li_no_grant got=%0d exp=0", bad); end
    level_in = 3'd1;
    step(1);
    n_checks++; if (cooling !== 1'b1) begin n_fail++; $display("FAIL li_restart got=%b exp=1", cooling); end
  endtask

  // T6: async reset during the grant pulse.
  task automatic test_reset_in_grant();
    int n;
    fire_req = 8'h10; slot_free = 4'h4;
    n = 0;
    while (cooling && n < 70) begin tick(); n++; step(2); end
    n_checks++; if (n !== 60) begin n_fail++; $display("FAIL rg_cool_ticks got=%0d exp=60", n); end
    tick();
    n_checks++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL rg_gv got=%b exp=1", grant_valid); end
    n_checks++; if (grant_id !== 3'd4) begin n_fail++; $display("FAIL rg_id got=%0d exp=4", grant_id); end
    n_checks++; if (grant_slot !== 2'd2) begin n_fail++; $display("FAIL rg_slot got=%0d exp=2", grant_slot); end
    rst = 1'b1;
    #1;
    n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL rg_cut_gv got=%b exp=0", grant_valid); end
    n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL rg_cut_id got=%0d exp=0", grant_id); end
    n_checks++; if (grant_slot !== 2'd0) begin n_fail++; $display("FAIL rg_cut_slot got=%0d exp=0", grant_slot); end
    n_checks++; if (cooling !== 1'b0) begin n_fail++; $display("FAIL rg_cut_cooling got=%b exp=0", cooling); end
    level_in = 3'd0;
    step(2);
    rst = 1'b0;
    step(1);
    tick();
    n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL rg_idle_gv got=%b exp=0", grant_valid); end
    n_checks++; if (cooling !== 1'b0) begin n_fail++; $display("FAIL rg_idle_cooling got=%b exp=0", cooling); end
    step(2);
  endtask

  initial begin
    test_reset();
    test_cooldown_l1();
    test_round_robin();
    test_level_change_tick();
    test_level2_rr();
    test_no_slot();
    test_level_idle();
    test_reset_in_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
